// File: rtl/fpro_mmio_arbiter.sv
// Two-master round-robin arbiter in front of the FPro MMIO bus.
// Each granted request becomes one registered strobe cycle (ISSUE)
// followed by one ready cycle (RESP) back to the winning master.
//
// state | meaning
// IDLE  | sample requests, pick a winner, latch its fields
// ISSUE | single-cycle strobe on the MMIO bus, capture read data
// RESP  | single-cycle ready pulse to the granted master
module fpro_mmio_arbiter #(
  parameter int ADDR_W = 21,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_cs,
  input  logic              m0_wr,
  input  logic              m0_rd,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wr_data,
  output logic [DATA_W-1:0] m0_rd_data,
  output logic              m0_ready,
  input  logic              m1_cs,
  input  logic              m1_wr,
  input  logic              m1_rd,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wr_data,
  output logic [DATA_W-1:0] m1_rd_data,
  output logic              m1_ready,
  output logic              mmio_cs,
  output logic              mmio_wr,
  output logic              mmio_rd,
  output logic [ADDR_W-1:0] mmio_addr,
  output logic [DATA_W-1:0] mmio_wr_data,
  input  logic [DATA_W-1:0] mmio_rd_data
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t            state, state_next;
  logic              gnt_id;
  logic              op_wr;
  logic              last_grant;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wr_data_reg;
  logic [DATA_W-1:0] rd_reg;

  logic req0, req1;
  logic grant_en, grant_sel;

  // A request needs cs plus at least one qualifier; wr wins over rd.
  assign req0 = m0_cs & (m0_wr | m0_rd);
  assign req1 = m1_cs & (m1_wr | m1_rd);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state, grant decision and bus/ready decode from the state register.
  always_comb begin
    state_next = state;
    grant_en   = 1'b0;
    grant_sel  = 1'b0;
    mmio_cs    = 1'b0;
    mmio_wr    = 1'b0;
    mmio_rd    = 1'b0;
    m0_ready   = 1'b0;
    m1_ready   = 1'b0;
    case (state)
      IDLE: begin
        grant_en  = req0 | req1;
        grant_sel = (req0 & req1) ? ~last_grant : req1;
        if (grant_en) state_next = ISSUE;
      end
      ISSUE: begin
        mmio_cs    = 1'b1;
        mmio_wr    = op_wr;
        mmio_rd    = ~op_wr;
        state_next = RESP;
      end
      RESP: begin
        m0_ready   = ~gnt_id;
        m1_ready   = gnt_id;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Latch the winner's request in IDLE and capture read data in ISSUE.
  always_ff @(posedge clk) begin
    if (reset) begin
      gnt_id      <= 1'b0;
      op_wr       <= 1'b0;
      last_grant  <= 1'b1;
      addr_reg    <= '0;
      wr_data_reg <= '0;
      rd_reg      <= '0;
    end else begin
      if (grant_en) begin
        gnt_id      <= grant_sel;
        last_grant  <= grant_sel;
        op_wr       <= grant_sel ? m1_wr : m0_wr;
        addr_reg    <= grant_sel ? m1_addr : m0_addr;
        wr_data_reg <= grant_sel ? m1_wr_data : m0_wr_data;
      end
      if (state == ISSUE && !op_wr) rd_reg <= mmio_rd_data;
    end
  end

  assign mmio_addr    = addr_reg;
  assign mmio_wr_data = wr_data_reg;
  assign m0_rd_data   = rd_reg;
  assign m1_rd_data   = rd_reg;

endmodule

// File: tb/tb_fpro_mmio_arbiter.sv
// Scoreboard bench for fpro_mmio_arbiter: stimulus pushes expected
// strobes and ready pulses (with their cycle numbers) into queues, and a
// negedge monitor pops and compares whenever the DUT presents one.
module tb_fpro_mmio_arbiter;

  localparam int ADDR_W = 21;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              m0_cs, m0_wr, m0_rd, m1_cs, m1_wr, m1_rd;
  logic [ADDR_W-1:0] m0_addr, m1_addr;
  logic [DATA_W-1:0] m0_wr_data, m1_wr_data;
  logic [DATA_W-1:0] m0_rd_data, m1_rd_data;
  logic              m0_ready, m1_ready;
  logic              mmio_cs, mmio_wr, mmio_rd;
  logic [ADDR_W-1:0] mmio_addr;
  logic [DATA_W-1:0] mmio_wr_data;
  logic [DATA_W-1:0] mmio_rd_data;

  fpro_mmio_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset),
    .m0_cs(m0_cs), .m0_wr(m0_wr), .m0_rd(m0_rd), .m0_addr(m0_addr),
    .m0_wr_data(m0_wr_data), .m0_rd_data(m0_rd_data), .m0_ready(m0_ready),
    .m1_cs(m1_cs), .m1_wr(m1_wr), .m1_rd(m1_rd), .m1_addr(m1_addr),
    .m1_wr_data(m1_wr_data), .m1_rd_data(m1_rd_data), .m1_ready(m1_ready),
    .mmio_cs(mmio_cs), .mmio_wr(mmio_wr), .mmio_rd(mmio_rd),
    .mmio_addr(mmio_addr), .mmio_wr_data(mmio_wr_data),
    .mmio_rd_data(mmio_rd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    int              cyc;
    logic            wr;
    logic [31:0]     addr;
    logic [31:0]     data;
  } strobe_t;

  typedef struct {
    int              cyc;
    logic            id;
    logic [31:0]     data;
  } ready_t;

  strobe_t sq[$];
  ready_t  rq[$];
  int      cyc = 0;
  int      checks = 0;
  int      errors = 0;
  int      strobe_cnt = 0;
  int      ready_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_strobe(input int c, input logic wr, input logic [31:0] a, input logic [31:0] d);
    strobe_t e;
    e.cyc = c; e.wr = wr; e.addr = a; e.data = d;
    sq.push_back(e);
  endtask

  task automatic push_ready(input int c, input logic id, input logic [31:0] d);
    ready_t e;
    e.cyc = c; e.id = id; e.data = d;
    rq.push_back(e);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_mmio_cs"}, 32'(mmio_cs), 32'd0);
    chk({tag, "_mmio_wr"}, 32'(mmio_wr), 32'd0);
    chk({tag, "_mmio_rd"}, 32'(mmio_rd), 32'd0);
    chk({tag, "_mmio_addr"}, 32'(mmio_addr), 32'd0);
    chk({tag, "_mmio_wr_data"}, mmio_wr_data, 32'd0);
    chk({tag, "_m0_ready"}, 32'(m0_ready), 32'd0);
    chk({tag, "_m1_ready"}, 32'(m1_ready), 32'd0);
    chk({tag, "_m0_rd_data"}, m0_rd_data, 32'd0);
    chk({tag, "_m1_rd_data"}, m1_rd_data, 32'd0);
  endtask

  // Monitor: compare every strobe and ready pulse against the scoreboard.
  always @(negedge clk) begin
    strobe_t s;
    ready_t  r;
    if (!mmio_cs && (mmio_wr || mmio_rd)) begin
      checks++; errors++;
      $display("FAIL stray_qualifier: wr=%0d rd=%0d with cs=0 (cycle %0d)", mmio_wr, mmio_rd, cyc);
    end
    if (mmio_cs) begin
      strobe_cnt++;
      if (sq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_strobe: got strobe addr=0x%06h required none (cycle %0d)", mmio_addr, cyc);
      end else begin
        s = sq.pop_front();
        chk("strobe_cycle", 32'(cyc), 32'(s.cyc));
        chk("strobe_wr", 32'(mmio_wr), 32'(s.wr));
        chk("strobe_rd", 32'(mmio_rd), 32'(!s.wr));
        chk("strobe_addr", 32'(mmio_addr), s.addr);
        chk("strobe_wr_data", mmio_wr_data, s.data);
      end
    end
    if (m0_ready || m1_ready) begin
      ready_cnt++;
      if (rq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_ready: got m0=%0d m1=%0d required none (cycle %0d)", m0_ready, m1_ready, cyc);
      end else begin
        r = rq.pop_front();
        chk("ready_cycle", 32'(cyc), 32'(r.cyc));
        chk("ready_m0", 32'(m0_ready), 32'(!r.id));
        chk("ready_m1", 32'(m1_ready), 32'(r.id));
        chk("ready_rd_data", r.id ? m1_rd_data : m0_rd_data, r.data);
      end
    end
  end

  initial begin
    int t;
    int s0, r0;
    reset = 1'b1;
    m0_cs = 0; m0_wr = 0; m0_rd = 0; m0_addr = '0; m0_wr_data = '0;
    m1_cs = 0; m1_wr = 0; m1_rd = 0; m1_addr = '0; m1_wr_data = '0;
    mmio_rd_data = '0;
    tick(3);
    chk_idle_outputs("reset");
    reset = 1'b0;
    tick(2);

    // Single read from master 0.
    mmio_rd_data = 32'hDEADBEEF;
    m0_cs = 1; m0_rd = 1; m0_addr = 21'h00123; m0_wr_data = 32'h0;
    t = cyc;
    push_strobe(t + 1, 1'b0, 32'h00123, 32'h0);
    push_ready(t + 2, 1'b0, 32'hDEADBEEF);
    tick(3);
    m0_cs = 0; m0_rd = 0;
    tick(2);

    // Single write from master 1; read data register must keep old value.
    mmio_rd_data = 32'h11111111;
    m1_cs = 1; m1_wr = 1; m1_addr = 21'h00040; m1_wr_data = 32'hA5A50001;
    t = cyc;
    push_strobe(t + 1, 1'b1, 32'h00040, 32'hA5A50001);
    push_ready(t + 2, 1'b1, 32'hDEADBEEF);
    tick(3);
    m1_cs = 0; m1_wr = 0;
    tick(2);

    // Tie right after reset: master 0 first, then master 1.
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);
    mmio_rd_data = 32'h33333333;
    m0_cs = 1; m0_rd = 1; m0_addr = 21'h00010; m0_wr_data = 32'h0;
    m1_cs = 1; m1_wr = 1; m1_addr = 21'h00020; m1_wr_data = 32'h00000022;
    t = cyc;
    push_strobe(t + 1, 1'b0, 32'h00010, 32'h0);
    push_ready(t + 2, 1'b0, 32'h33333333);
    push_strobe(t + 4, 1'b1, 32'h00020, 32'h00000022);
    push_ready(t + 5, 1'b1, 32'h33333333);
    tick(3);
    m0_cs = 0; m0_rd = 0;
    tick(3);
    m1_cs = 0; m1_wr = 0;
    tick(2);

    // Fairness: both hold requests for six transactions.
    mmio_rd_data = 32'h44444444;
    s0 = strobe_cnt; r0 = ready_cnt;
    m0_cs = 1; m0_rd = 1; m0_addr = 21'h00100; m0_wr_data = 32'h00000100;
    m1_cs = 1; m1_wr = 1; m1_addr = 21'h00200; m1_wr_data = 32'hBEEF0000;
    t = cyc;
    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0) push_strobe(t + 3*k + 1, 1'b0, 32'h00100, 32'h00000100);
      else            push_strobe(t + 3*k + 1, 1'b1, 32'h00200, 32'hBEEF0000);
      push_ready(t + 3*k + 2, 1'((k % 2) == 1), 32'h44444444);
    end
    tick(18);
    m0_cs = 0; m0_rd = 0; m1_cs = 0; m1_wr = 0;
    tick(2);
    chk("fair_strobe_count", 32'(strobe_cnt - s0), 32'd6);
    chk("fair_ready_count", 32'(ready_cnt - r0), 32'd6);

    // Reset in the ISSUE cycle of a master 0 read.
    mmio_rd_data = 32'h66666666;
    m0_cs = 1; m0_rd = 1; m0_addr = 21'h00055; m0_wr_data = 32'h0;
    t = cyc;
    push_strobe(t + 1, 1'b0, 32'h00055, 32'h0);
    tick(1);
    reset = 1'b1;
    tick(1);
    chk_idle_outputs("midreset");
    reset = 1'b0;
    m0_cs = 0; m0_rd = 0;
    tick(4);
    mmio_rd_data = 32'h12345678;
    m0_cs = 1; m0_rd = 1; m0_addr = 21'h00077;
    t = cyc;
    push_strobe(t + 1, 1'b0, 32'h00077, 32'h0);
    push_ready(t + 2, 1'b0, 32'h12345678);
    tick(3);
    m0_cs = 0; m0_rd = 0;
    tick(2);

    // cs without qualifiers is not a request.
    s0 = strobe_cnt;
    m0_cs = 1;
    tick(5);
    m0_cs = 0;
    tick(2);
    chk("cs_only_no_strobe", 32'(strobe_cnt - s0), 32'd0);

    // wr and rd together are treated as a write.
    mmio_rd_data = 32'h77777777;
    m1_cs = 1; m1_wr = 1; m1_rd = 1; m1_addr = 21'h00099; m1_wr_data = 32'h0000CAFE;
    t = cyc;
    push_strobe(t + 1, 1'b1, 32'h00099, 32'h0000CAFE);
    push_ready(t + 2, 1'b1, 32'h12345678);
    tick(3);
    m1_cs = 0; m1_wr = 0; m1_rd = 0;
    tick(4);

    chk("strobe_queue_drained", 32'(sq.size()), 32'd0);
    chk("ready_queue_drained", 32'(rq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fpro_mmio_arbiter.md
# fpro_mmio_arbiter

Two-master arbiter that shares the single FPro MMIO bus (`mmio_cs`/`mmio_wr`/`mmio_rd`/`mmio_addr`/`mmio_wr_data`/`mmio_rd_data`) between the MicroBlaze MCS bridge (master 0) and a second bus master such as a DMA or debug engine (master 1). It sits between the bridge's `fp_*` outputs and the MMIO subsystem. It registers each granted request, issues a single-cycle strobe to the MMIO subsystem, and captures read data. It returns a one-cycle `ready` pulse to the winning master. Arbitration is round-robin.

## Interface
- ADDR_W, 21, MMIO word-address width
- DATA_W, 32, data width
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- m0_cs, m1_cs  in  1  master chip select; request held until that master's ready
- m0_wr, m1_wr  in  1  write request qualifier
- m0_rd, m1_rd  in  1  read request qualifier
- m0_addr, m1_addr  in  ADDR_W  target address
- m0_wr_data, m1_wr_data  in  DATA_W  write data
- m0_rd_data, m1_rd_data  out  DATA_W  read data, valid while ready=1
- m0_ready, m1_ready  out  1  transaction-complete pulse
- mmio_cs, mmio_wr, mmio_rd  out  1  strobes to the MMIO subsystem
- mmio_addr  out  ADDR_W  address to the MMIO subsystem
- mmio_wr_data  out  DATA_W  write data to the MMIO subsystem
- mmio_rd_data  in  DATA_W  combinational read data from the MMIO subsystem

## Operation
- A request from master i is valid when mi_cs & (mi_wr | mi_rd).
- If mi_wr and mi_rd are both high, the transaction is a write and rd is ignored.
- cs alone, with neither wr nor rd, is not a request.
- The FSM has three states: IDLE, ISSUE, RESP.
- IDLE:
  - With no valid request, stay in IDLE.
  - With exactly one valid request, grant that master.
  - With both valid, grant the master that is not `last_grant`.
  - On grant, register gnt_id, op (write/read), addr and wr_data; set last_grant=gnt_id; go to ISSUE.
- ISSUE (exactly 1 cycle):
  - mmio_cs=1; mmio_wr=op_wr; mmio_rd=!op_wr.
  - mmio_addr and mmio_wr_data come from the registers.
  - On reads, capture mmio_rd_data into rd_reg at the end of the cycle; writes leave rd_reg unchanged.
  - Go to RESP.
- RESP (exactly 1 cycle):
  - m<gnt_id>_ready=1; the other master's ready stays 0.
  - Both mi_rd_data outputs drive rd_reg. Only the ready master may sample it.
  - Go to IDLE.
- The master must drop cs/wr/rd, or present a new request, in the cycle after its ready.
- Requests are never split or merged. The bus carries exactly one strobe per granted request.
- Changing request fields while waiting is a master protocol violation. Sampling happens only in IDLE; the arbiter does not check for it.
- mmio_addr and mmio_wr_data hold their last registered values outside ISSUE. Strobes are 0 outside ISSUE.

## Timing
- Reset values:
  - State IDLE; last_grant=1, so master 0 wins the first tie.
  - mmio_cs, mmio_wr, mmio_rd = 0; mmio_addr = 0; mmio_wr_data = 0.
  - rd_reg = 0; both ready = 0; both rd_data = 0.
- Latency: request visible in IDLE at cycle N -> strobe at cycle N+1 -> ready at cycle N+2.
- Throughput: at most one transaction per 3 cycles, since the next IDLE sample is at N+3.
- Fairness: under continuous requests from both masters, grants alternate 0,1,0,1, and no master waits more than one transaction.
- Simultaneous events: a new request arriving during ISSUE/RESP is held until IDLE. A request from the ready master at N+3 competes normally with the other master.
- Reset asserted mid-transaction (ISSUE or RESP): next cycle is IDLE with all outputs at reset values. No ready is ever produced for the aborted transaction. A strobe already issued is not retracted.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Single read from master 0: m0 reads addr 0x00123 while mmio_rd_data=0xDEADBEEF -> mmio_rd=1 and mmio_addr=0x00123 at N+1; m0_ready=1 and m0_rd_data=0xDEADBEEF at N+2; m1_ready stays 0.
- Single write from master 1: m1 writes 0xA5A5_0001 to 0x00040 -> mmio_wr=1 for exactly one cycle with that addr/data; m1_ready at N+2; rd_reg unchanged.
- Tie after reset: both request at the same cycle -> master 0 is served first (ready at N+2), master 1 next (strobe at N+4, ready at N+5).
- Fairness: both hold requests for 6 transactions -> grant order 0,1,0,1,0,1; strobe count equals ready count equals 6.
- Reset mid-operation: assert reset in the ISSUE cycle of an m0 read -> no m0_ready; all outputs 0 next cycle; a fresh m0 read after reset completes with correct data.
- Qualifier edge cases: cs=1 with wr=rd=0 for 5 cycles -> no strobe. cs=wr=rd=1 -> only mmio_wr asserts.
